// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives data_bus read addresses and
// buffers returned words in a 2-entry FIFO with a valid/ready output.
`ifndef INITIAL_PC
`define INITIAL_PC 64'h0
`endif
`ifndef MEM_END
`define MEM_END 64'hFFFF
`endif

module fetch_unit #(
    parameter logic [63:0] INIT_PC   = `INITIAL_PC,
    parameter logic [63:0] MEM_LIMIT = `MEM_END,
    parameter logic [63:0] PC_STEP   = 64'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [63:0] out_instr,
    output logic        out_fault,
    output logic        halted,
    output logic [63:0] bus_addr,
    output logic        bus_rw,
    output logic [63:0] bus_write,
    input  logic [63:0] bus_read,
    input  logic        bus_exception
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] instr;
        logic        fault;
    } entry_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] bus_addr_q, bus_addr_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic        inflight_q, inflight_d;
    logic        inflight_epoch_q, inflight_epoch_d;
    logic        epoch_q, epoch_d;
    logic [1:0]  count_q, count_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    entry_t      new_e;

    logic run, pop, cap, exc_cap, oob, room, issue, oob_push, push;

    assign run      = (state_q == ST_RUN);
    assign pop      = (count_q != 2'd0) & out_ready;
    // A response belongs to us only if last cycle issued in the current epoch.
    assign cap      = inflight_q & (inflight_epoch_q == epoch_q) & run & ~redirect_valid;
    assign exc_cap  = cap & bus_exception;
    assign oob      = run & (pc_q > MEM_LIMIT);
    assign room     = ({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
    assign issue    = run & ~oob & room & ~redirect_valid;
    // The synthetic fault waits for the last real response so ordering holds.
    assign oob_push = oob & ~inflight_q & ~redirect_valid & ((count_q != 2'd2) | pop);
    assign push     = cap | oob_push;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (redirect_valid)             state_d = ST_RUN;
        else if (exc_cap | oob_push)    state_d = ST_HALT;
    end

    // FSM: outputs
    always_comb begin
        halted = (state_q == ST_HALT);
    end

    always_comb begin
        new_e.pc    = cap ? req_pc_q : pc_q;
        new_e.instr = (cap & ~bus_exception) ? bus_read : 64'd0;
        new_e.fault = ~cap | bus_exception;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc;
        else if (issue)     pc_d = pc_q + PC_STEP;
        // Never present an address past the limit to the bus.
        if (redirect_valid)          bus_addr_d = redirect_pc;
        else if (pc_d <= MEM_LIMIT)  bus_addr_d = pc_d;
        else                         bus_addr_d = bus_addr_q;
        inflight_d       = issue;
        inflight_epoch_d = issue ? epoch_q : inflight_epoch_q;
        req_pc_d         = issue ? pc_q : req_pc_q;
        epoch_d          = epoch_q ^ redirect_valid;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = new_e;
                    else                 tail_d = new_e;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = new_e;
                    end else begin
                        head_d = tail_q;
                        tail_d = new_e;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q             <= INIT_PC;
            bus_addr_q       <= INIT_PC;
            req_pc_q         <= 64'd0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            epoch_q          <= 1'b0;
            count_q          <= 2'd0;
            head_q           <= '0;
            tail_q           <= '0;
        end else begin
            pc_q             <= pc_d;
            bus_addr_q       <= bus_addr_d;
            req_pc_q         <= req_pc_d;
            inflight_q       <= inflight_d;
            inflight_epoch_q <= inflight_epoch_d;
            epoch_q          <= epoch_d;
            count_q          <= count_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_pc    = head_q.pc;
    assign out_instr = head_q.instr;
    assign out_fault = head_q.fault;
    assign bus_addr  = bus_addr_q;
    assign bus_rw    = 1'b0;
    assign bus_write = 64'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: registered memory model plus a stream-level model of
// the expected fetch sequence (PC runs from each restart until fault or limit).
module tb_fetch_unit;
    localparam logic [63:0] INIT  = 64'h0;
    localparam logic [63:0] LIMIT = 64'h7F;
    localparam logic [63:0] STEP  = 64'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_instr;
    logic        out_fault;
    logic        halted;
    logic [63:0] bus_addr;
    logic        bus_rw;
    logic [63:0] bus_write;
    logic [63:0] bus_read = 64'd0;
    logic        bus_exception = 1'b0;

    logic        exc_arm = 1'b0;
    logic [63:0] exc_addr = 64'd0;

    int total = 0;
    int bad   = 0;

    // stream model state
    logic [63:0] m_pc;
    bit          m_done;
    bit          m_arm;
    logic [63:0] m_exc;
    bit          p_stall;
    logic [63:0] p_pc, p_ins;
    logic        p_f;

    fetch_unit #(.INIT_PC(INIT), .MEM_LIMIT(LIMIT), .PC_STEP(STEP)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault),
        .halted(halted), .bus_addr(bus_addr), .bus_rw(bus_rw),
        .bus_write(bus_write), .bus_read(bus_read), .bus_exception(bus_exception)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem(input logic [63:0] a);
        return {~a[31:0], a[31:0]};
    endfunction

    always @(posedge clk) begin
        bus_read      <= mem(bus_addr);
        bus_exception <= exc_arm && (bus_addr == exc_addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic model_restart(input logic [63:0] p);
        m_pc    = p;
        m_done  = 0;
        m_arm   = exc_arm;
        m_exc   = exc_addr;
        p_stall = 0;
    endtask

    // Drive one cycle's inputs, check the handshake happening at its end,
    // then advance to the next negedge.
    task automatic tick(input bit rdy, input bit rv, input logic [63:0] rpc);
        logic [63:0] e_pc, e_ins;
        logic        e_f;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (p_stall) begin
            chk1("hold_valid", out_valid, 1'b1);
            chk("hold_pc", out_pc, p_pc);
            chk("hold_instr", out_instr, p_ins);
            chk1("hold_fault", out_fault, p_f);
        end
        if (m_done) begin
            chk1("no_entry_after_end", out_valid && out_ready, 1'b0);
        end else if (out_valid && out_ready) begin
            if (m_pc > LIMIT || (m_arm && m_pc == m_exc)) begin
                e_pc = m_pc; e_ins = 64'd0; e_f = 1'b1; m_done = 1;
            end else begin
                e_pc = m_pc; e_ins = mem(m_pc); e_f = 1'b0; m_pc = m_pc + STEP;
            end
            chk("entry_pc", out_pc, e_pc);
            chk("entry_instr", out_instr, e_ins);
            chk1("entry_fault", out_fault, e_f);
            if (e_f) chk1("fault_halted", halted, 1'b1);
        end
        p_stall = out_valid && !out_ready && !rv;
        p_pc = out_pc; p_ins = out_instr; p_f = out_fault;
        if (rv) model_restart(rpc);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        bit          rdy, rv;
        logic [63:0] rpc;
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        model_restart(INIT);
        repeat (2) @(negedge clk);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk("rst_bus_addr", bus_addr, INIT);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", out_instr, 64'd0);
        chk1("rst_out_fault", out_fault, 1'b0);
        chk1("rst_bus_rw", bus_rw, 1'b0);
        chk("rst_bus_write", bus_write, 64'd0);

        // release: first entry exactly two cycles later, then one per cycle
        rst = 1'b0;
        tick(1, 0, 0);
        chk1("lat_c1_valid", out_valid, 1'b0);
        tick(1, 0, 0);
        chk1("lat_c2_valid", out_valid, 1'b1);
        chk("lat_c2_pc", out_pc, INIT);
        chk("lat_c2_instr", out_instr, mem(INIT));
        for (int i = 0; i < 8; i++) begin
            chk1("thru_valid", out_valid, 1'b1);
            tick(1, 0, 0);
        end

        // stall: two entries buffered, next PC not yet issued
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        chk1("stall_valid", out_valid, 1'b1);
        chk("stall_depth", bus_addr, out_pc + 64'd2);
        for (int i = 0; i < 6; i++) tick(1, 0, 0);

        // redirect with work in flight
        tick(0, 1, 64'h40);
        chk1("redir_r1_valid", out_valid, 1'b0);
        chk("redir_r1_addr", bus_addr, 64'h40);
        tick(1, 0, 0);
        chk1("redir_r2_valid", out_valid, 1'b0);
        tick(1, 0, 0);
        chk1("redir_r3_valid", out_valid, 1'b1);
        chk("redir_r3_pc", out_pc, 64'h40);
        for (int i = 0; i < 6; i++) tick(1, 0, 0);

        // bus exception on 0x10
        exc_arm = 1'b1; exc_addr = 64'h10;
        tick(1, 1, 64'h0C);
        for (int i = 0; i < 14; i++) tick(1, 0, 0);
        chk1("exc_seen", m_done, 1'b1);
        chk1("exc_halted", halted, 1'b1);
        chk1("exc_idle", out_valid, 1'b0);
        exc_arm = 1'b0;
        tick(1, 1, 64'h0);
        chk1("halt_fall", halted, 1'b0);
        chk("resume_addr", bus_addr, 64'h0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk1("resume_valid", out_valid, 1'b1);
        chk("resume_pc", out_pc, 64'h0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0);

        // end of memory
        tick(1, 1, LIMIT - 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk1("no_oob_bus", bus_addr > LIMIT, 1'b0);
            tick(1, 0, 0);
        end
        chk1("limit_seen", m_done, 1'b1);
        chk1("limit_halted", halted, 1'b1);

        // reset with a full buffer
        tick(1, 1, 64'h20);
        for (int i = 0; i < 4; i++) tick(1, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        chk1("full_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rst2_valid", out_valid, 1'b0);
        chk("rst2_bus_addr", bus_addr, INIT);
        chk1("rst2_halted", halted, 1'b0);
        exc_arm = 1'b0;
        model_restart(INIT);
        @(negedge clk);
        rst = 1'b0;
        tick(1, 0, 0);
        chk1("rst2_c1_valid", out_valid, 1'b0);
        tick(1, 0, 0);
        chk1("rst2_c2_valid", out_valid, 1'b1);
        chk("rst2_c2_pc", out_pc, INIT);

        // random traffic: stalls, redirects, exceptions, limit hits
        for (int i = 0; i < 1500; i++) begin
            rdy = ($urandom % 10) < 7;
            rv  = ($urandom % 40) == 0;
            rpc = 64'd0;
            if (rv) begin
                if ($urandom % 2) rpc = LIMIT - 64'($urandom_range(0, 6));
                else              rpc = 64'($urandom_range(0, 127));
                exc_arm  = ($urandom % 2) == 0;
                exc_addr = rpc + 64'($urandom_range(0, 10));
            end
            tick(rdy, rv, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
